fsm_divsqrt_iter: RTL and testbench
===================================

Name: fsm_divsqrt_iter

Overview:
- Parametrised control FSM for the Goldschmidt divide/square-root datapath in the FPU.
- Sequences the register enables and operand-mux selects for regA/B/C/D, the remainder register and the q/qm/qp registers.
- Generalises the fixed 3-iteration controller:
  - iteration count is chosen at run time per operation (single vs double precision);
  - adds abort, early termination on error, a busy flag and an iteration index.

Parameters:
- NITER_MAX, 7: largest supported iteration count.
- ITW, $clog2(NITER_MAX+1): width of the iteration count and index.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle request; accepted only in IDLE
- op_type  input  1  0 = divide, 1 = sqrt; sampled with start
- niter  input  ITW  iteration count; sampled with start; 0 is treated as 1; values above NITER_MAX saturate to NITER_MAX
- error  input  1  operand exception; sampled with start
- abort  input  1  flush; ignored in IDLE
- busy  output  1  high from the cycle after start until DONE inclusive
- done  output  1  one-cycle completion pulse
- load_rega, load_regb, load_regc, load_regd, load_regr, load_regs  output  1 each  register enables
- sel_muxa  output  3  muxA select
- sel_muxb  output  3  muxB select
- sel_muxr  output  1  remainder mux select
- iter  output  ITW  current multiply-iteration index (1..n); 0 outside iterations

Behaviour:
- Reset state:
  - reset=0 forces IDLE asynchronously; count=0; latched op/n cleared.
  - All outputs 0: done, busy, all loads, sel_muxa=000, sel_muxb=000, sel_muxr=0, iter=0.
- Control-word notation: loads / a=sel_muxa / b=sel_muxb / r=sel_muxr. Any unlisted load is 0; r=0 unless stated.
- Output timing: outputs are combinational from state. The exception is IDLE, where the start cycle drives the init word in the same cycle.
- Divide sequence, n = latched iteration count:
  - IDLE & start & !error & op=0: ldB a=001 b=001 -> D_INIT.
  - D_INIT: ldA ldC a=010 b=000 -> D_B.
  - D_B: ldB a=011 b=011; count++.
    - If count==n (after increment) -> QUOT, else -> D_AC.
  - D_AC: ldA ldC a=000 b=010 -> D_B.
- Sqrt sequence:
  - IDLE & start & !error & op=1: ldB a=010 b=000 -> S_D0.
  - S_D0: ldD a=010 b=001 -> S_AC0.
  - S_AC0: ldA ldC a=001 b=100 -> S_B.
  - S_B: ldB a=011 b=011; count++ -> S_D.
  - S_D: ldD a=000 b=011 -> S_AC.
  - S_AC: ldA ldC a=100 b=010.
    - If count==n -> QUOT, else -> S_B.
- Common tail:
  - QUOT: ldS -> REM.
  - REM: ldR r=1 -> DONE.
    - divide: a=000 b=000;
    - sqrt: a=011 b=110.
  - DONE: done=1 -> IDLE.
- Latency, with the start cycle as cycle 0:
  - Divide: done at cycle 2n+3 (n=3 -> 9).
  - Sqrt: done at cycle 3n+5 (n=3 -> 14).
- Error:
  - start & error: no loads in the start cycle -> DONE next cycle.
  - done therefore pulses at cycle 1; ldS and ldR are never asserted.
- Abort:
  - Any non-IDLE state with abort=1 -> IDLE next cycle; all loads in that cycle are forced to 0.
  - No done pulse; count cleared.
  - Abort in DONE: done still pulses and the FSM returns to IDLE as normal.
- A start outside IDLE is ignored. A start in the DONE cycle is ignored; back-to-back operations need one IDLE cycle between them.
- iter reflects the count value during the B states. The count is cleared in IDLE.
- Illegal or unused state encodings -> IDLE with all outputs 0.

Decomposition:
- Shared package fpdiv_pkg:
  - state enum;
  - control-word constants for mux selects (MUXA_INIT=001, MUXA_FB=011, ...);
  - a packed control-word struct {loads[5:0], sel_muxa, sel_muxb, sel_muxr}.
- Sub-module divsqrt_iter_cnt:
  - ITW-bit counter with clear, increment and terminal compare (count==n);
  - n latched with saturation and zero-to-one mapping.

Test Plan:
- Divide, niter=3: start@0 -> ldB@0, ldA/ldC@1,3,5, ldB@2,4,6, ldS@7, ldR r=1@8, done@9; sel values per cycle as specified.
- Sqrt, niter=3: start@0 -> ldD@1,4,7,10, ldB@3,6,9, ldS@12, ldR a=011 b=110 r=1@13, done@14.
- Divide with niter=1, niter=0, and niter=NITER_MAX+1 (saturates): done@5, done@5, done@2*NITER_MAX+3 respectively; iter peaks at the effective n.
- start with error=1 -> done@1, no load ever asserted, busy@1 only.
- Abort during sqrt S_AC at cycle 5 -> IDLE@6, done never pulses, next start accepted normally; asserting reset=0 mid-divide clears all outputs immediately.
- start held high across DONE -> ignored in DONE, new operation accepted in the following IDLE cycle.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared definitions for the Goldschmidt divide/sqrt controller: state codes,
// register-enable masks, operand-mux select codes and the packed control word.
package fpdiv_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_D_INIT = 4'd1;
    localparam state_t ST_D_B    = 4'd2;
    localparam state_t ST_D_AC   = 4'd3;
    localparam state_t ST_S_D0   = 4'd4;
    localparam state_t ST_S_AC0  = 4'd5;
    localparam state_t ST_S_B    = 4'd6;
    localparam state_t ST_S_D    = 4'd7;
    localparam state_t ST_S_AC   = 4'd8;
    localparam state_t ST_QUOT   = 4'd9;
    localparam state_t ST_REM    = 4'd10;
    localparam state_t ST_DONE   = 4'd11;

    // Bit positions of the register enables inside the control word.
    localparam int LD_A = 0;
    localparam int LD_B = 1;
    localparam int LD_C = 2;
    localparam int LD_D = 3;
    localparam int LD_R = 4;
    localparam int LD_S = 5;

    localparam logic [5:0] LDM_NONE = 6'b000000;
    localparam logic [5:0] LDM_A    = 6'b000001 << LD_A;
    localparam logic [5:0] LDM_B    = 6'b000001 << LD_B;
    localparam logic [5:0] LDM_C    = 6'b000001 << LD_C;
    localparam logic [5:0] LDM_D    = 6'b000001 << LD_D;
    localparam logic [5:0] LDM_R    = 6'b000001 << LD_R;
    localparam logic [5:0] LDM_S    = 6'b000001 << LD_S;

    localparam logic [2:0] MUXA_NONE  = 3'b000;
    localparam logic [2:0] MUXA_INIT  = 3'b001;
    localparam logic [2:0] MUXA_SCALE = 3'b010;
    localparam logic [2:0] MUXA_FB    = 3'b011;
    localparam logic [2:0] MUXA_SQRT  = 3'b100;

    localparam logic [2:0] MUXB_NONE  = 3'b000;
    localparam logic [2:0] MUXB_INIT  = 3'b001;
    localparam logic [2:0] MUXB_AC    = 3'b010;
    localparam logic [2:0] MUXB_FB    = 3'b011;
    localparam logic [2:0] MUXB_SQRT  = 3'b100;
    localparam logic [2:0] MUXB_REM   = 3'b110;

    typedef struct packed {
        logic [5:0] loads;
        logic [2:0] sel_muxa;
        logic [2:0] sel_muxb;
        logic       sel_muxr;
    } ctrl_word_t;

    localparam ctrl_word_t CW_IDLE = '0;

    function automatic ctrl_word_t cw_make(input logic [5:0] loads, input logic [2:0] a,
                                           input logic [2:0] b, input logic r);
        ctrl_word_t w;
        w.loads    = loads;
        w.sel_muxa = a;
        w.sel_muxb = b;
        w.sel_muxr = r;
        return w;
    endfunction

endpackage

// File: rtl/fsm_divsqrt_iter_if.sv
// Request/response and datapath-control bundle between the FPU issue logic
// (master) and the divide/sqrt sequencer (slave).
interface fsm_divsqrt_iter_if #(
    parameter int ITW = 3
);
    logic           start;
    logic           op_type;
    logic [ITW-1:0] niter;
    logic           error;
    logic           abort;
    logic           busy;
    logic           done;
    logic           load_rega;
    logic           load_regb;
    logic           load_regc;
    logic           load_regd;
    logic           load_regr;
    logic           load_regs;
    logic [2:0]     sel_muxa;
    logic [2:0]     sel_muxb;
    logic           sel_muxr;
    logic [ITW-1:0] iter;

    modport master (
        output start, op_type, niter, error, abort,
        input  busy, done, load_rega, load_regb, load_regc, load_regd, load_regr, load_regs,
        input  sel_muxa, sel_muxb, sel_muxr, iter
    );

    modport slave (
        input  start, op_type, niter, error, abort,
        output busy, done, load_rega, load_regb, load_regc, load_regd, load_regr, load_regs,
        output sel_muxa, sel_muxb, sel_muxr, iter
    );
endinterface

// File: rtl/divsqrt_iter_cnt.sv
// Iteration counter: latches the effective iteration count (0 -> 1, clipped to
// NITER_MAX) and reports the terminal condition for the current and next count.
module divsqrt_iter_cnt #(
    parameter int NITER_MAX = 7,
    parameter int ITW       = $clog2(NITER_MAX + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           inc,
    input  logic           n_load,
    input  logic [ITW-1:0] n_in,
    output logic [ITW-1:0] iter_next,
    output logic           term,
    output logic           term_next
);
    localparam logic [ITW-1:0] N_MAX = ITW'(NITER_MAX);

    logic [ITW-1:0] cnt;
    logic [ITW-1:0] n_lat;
    logic [ITW-1:0] n_eff;

    always_comb begin
        if (n_in == '0)
            n_eff = ITW'(1);
        else if (n_in > N_MAX)
            n_eff = N_MAX;
        else
            n_eff = n_in;
    end

    assign iter_next = cnt + ITW'(1);
    assign term      = (cnt == n_lat);
    assign term_next = (iter_next == n_lat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            n_lat <= '0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (inc)
                cnt <= iter_next;
            if (n_load)
                n_lat <= n_eff;
        end
    end
endmodule

// File: rtl/fsm_divsqrt_iter.sv
// Goldschmidt divide/sqrt sequencer: walks the regA/B/C/D multiply loop for a
// run-time iteration count, then loads quotient and remainder registers.
module fsm_divsqrt_iter
    import fpdiv_pkg::*;
#(
    parameter int NITER_MAX = 7,
    parameter int ITW       = $clog2(NITER_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    fsm_divsqrt_iter_if.slave    bus
);
    state_t         state;
    state_t         state_nxt;
    logic           op_lat;
    ctrl_word_t     cw;
    logic           busy_c;
    logic           done_c;
    logic           cnt_clr;
    logic           cnt_inc;
    logic           n_load;
    logic           term;
    logic           term_next;
    logic [ITW-1:0] iter_next;
    logic [ITW-1:0] iter_c;

    divsqrt_iter_cnt #(
        .NITER_MAX (NITER_MAX),
        .ITW       (ITW)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .n_load    (n_load),
        .n_in      (bus.niter),
        .iter_next (iter_next),
        .term      (term),
        .term_next (term_next)
    );

    always_comb begin
        cw        = CW_IDLE;
        state_nxt = state;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        n_load    = 1'b0;
        iter_c    = '0;
        case (state)
            ST_IDLE: begin
                busy_c  = 1'b0;
                cnt_clr = 1'b1;
                // The init word is issued in the start cycle itself to save a cycle.
                if (bus.start) begin
                    n_load = 1'b1;
                    if (bus.error) begin
                        state_nxt = ST_DONE;
                    end else if (bus.op_type) begin
                        cw        = cw_make(LDM_B, MUXA_SCALE, MUXB_NONE, 1'b0);
                        state_nxt = ST_S_D0;
                    end else begin
                        cw        = cw_make(LDM_B, MUXA_INIT, MUXB_INIT, 1'b0);
                        state_nxt = ST_D_INIT;
                    end
                end
            end
            ST_D_INIT: begin
                cw        = cw_make(LDM_A | LDM_C, MUXA_SCALE, MUXB_NONE, 1'b0);
                state_nxt = ST_D_B;
            end
            ST_D_B: begin
                cw        = cw_make(LDM_B, MUXA_FB, MUXB_FB, 1'b0);
                cnt_inc   = 1'b1;
                iter_c    = iter_next;
                state_nxt = term_next ? ST_QUOT : ST_D_AC;
            end
            ST_D_AC: begin
                cw        = cw_make(LDM_A | LDM_C, MUXA_NONE, MUXB_AC, 1'b0);
                state_nxt = ST_D_B;
            end
            ST_S_D0: begin
                cw        = cw_make(LDM_D, MUXA_SCALE, MUXB_INIT, 1'b0);
                state_nxt = ST_S_AC0;
            end
            ST_S_AC0: begin
                cw        = cw_make(LDM_A | LDM_C, MUXA_INIT, MUXB_SQRT, 1'b0);
                state_nxt = ST_S_B;
            end
            ST_S_B: begin
                cw        = cw_make(LDM_B, MUXA_FB, MUXB_FB, 1'b0);
                cnt_inc   = 1'b1;
                iter_c    = iter_next;
                state_nxt = ST_S_D;
            end
            ST_S_D: begin
                cw        = cw_make(LDM_D, MUXA_NONE, MUXB_FB, 1'b0);
                state_nxt = ST_S_AC;
            end
            ST_S_AC: begin
                // The count was already advanced in S_B, so compare the live value.
                cw        = cw_make(LDM_A | LDM_C, MUXA_SQRT, MUXB_AC, 1'b0);
                state_nxt = term ? ST_QUOT : ST_S_B;
            end
            ST_QUOT: begin
                cw        = cw_make(LDM_S, MUXA_NONE, MUXB_NONE, 1'b0);
                state_nxt = ST_REM;
            end
            ST_REM: begin
                if (op_lat)
                    cw = cw_make(LDM_R, MUXA_FB, MUXB_REM, 1'b1);
                else
                    cw = cw_make(LDM_R, MUXA_NONE, MUXB_NONE, 1'b1);
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_c    = 1'b0;
                cnt_clr   = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase

        // DONE already returns to IDLE, so abort there only suppresses loads.
        if (bus.abort && (state != ST_IDLE)) begin
            cw.loads = LDM_NONE;
            if (state != ST_DONE) begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
                cnt_inc   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (n_load)
                op_lat <= bus.op_type;
        end
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.load_rega = cw.loads[LD_A];
    assign bus.load_regb = cw.loads[LD_B];
    assign bus.load_regc = cw.loads[LD_C];
    assign bus.load_regd = cw.loads[LD_D];
    assign bus.load_regr = cw.loads[LD_R];
    assign bus.load_regs = cw.loads[LD_S];
    assign bus.sel_muxa  = cw.sel_muxa;
    assign bus.sel_muxb  = cw.sel_muxb;
    assign bus.sel_muxr  = cw.sel_muxr;
    assign bus.iter      = iter_c;
endmodule

// File: tb/tb_fsm_divsqrt_iter.sv
// Directed bench for fsm_divsqrt_iter: cycle-exact control words for divide and
// sqrt, iteration-count edge cases, error, abort, reset and held-start behaviour.
module tb_fsm_divsqrt_iter;
    localparam int NITER_MAX = 6;
    localparam int ITW       = $clog2(NITER_MAX + 1);

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fsm_divsqrt_iter_if #(.ITW(ITW)) bus ();

    fsm_divsqrt_iter #(
        .NITER_MAX (NITER_MAX),
        .ITW       (ITW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {loads S R D C B A, muxa, muxb, muxr, busy, done, iter}
    logic [17:0] obs_w;
    assign obs_w = {bus.load_regs, bus.load_regr, bus.load_regd, bus.load_regc,
                    bus.load_regb, bus.load_rega, bus.sel_muxa, bus.sel_muxb,
                    bus.sel_muxr, bus.busy, bus.done, bus.iter};

    function automatic logic [17:0] W(input logic [5:0] ld, input logic [2:0] a,
                                      input logic [2:0] b, input logic r, input logic bsy,
                                      input logic dn, input logic [2:0] it);
        return {ld, a, b, r, bsy, dn, it};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick_in(input logic s);
        @(posedge clk);
        #1;
        bus.start = s;
    endtask

    task automatic step(input logic s, input string tag, input logic [17:0] e);
        tick_in(s);
        #1;
        chk(tag, 32'(obs_w), 32'(e));
    endtask

    task automatic run_len(input string tag, input logic op, input logic [2:0] n,
                           input int exp_done, input logic [2:0] exp_peak);
        int         dc;
        logic [2:0] pk;
        dc = -1;
        pk = '0;
        bus.op_type = op;
        bus.niter   = n;
        bus.error   = 1'b0;
        tick_in(1'b1);
        #1;
        for (int c = 1; c < 64 && dc < 0; c++) begin
            tick_in(1'b0);
            #1;
            if (bus.iter > pk) pk = bus.iter;
            if (bus.done) dc = c;
        end
        chk({tag, "_done"}, 32'(dc), 32'(exp_done));
        chk({tag, "_peak"}, 32'(pk), 32'(exp_peak));
    endtask

    initial begin
        int ndone;
        int k;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.op_type = 1'b0;
        bus.niter   = '0;
        bus.error   = 1'b0;
        bus.abort   = 1'b0;
        #3;
        chk("reset_state", 32'(obs_w), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Divide, n=3
        bus.op_type = 1'b0;
        bus.niter   = 3'd3;
        step(1'b1, "div_c0", W(6'b000010, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        step(1'b0, "div_c1", W(6'b000101, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0));
        step(1'b0, "div_c2", W(6'b000010, 3'b011, 3'b011, 1'b0, 1'b1, 1'b0, 3'd1));
        step(1'b0, "div_c3", W(6'b000101, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0));
        step(1'b0, "div_c4", W(6'b000010, 3'b011, 3'b011, 1'b0, 1'b1, 1'b0, 3'd2));
        step(1'b0, "div_c5", W(6'b000101, 3'b000, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0));
        step(1'b0, "div_c6", W(6'b000010, 3'b011, 3'b011, 1'b0, 1'b1, 1'b0, 3'd3));
        step(1'b0, "div_c7", W(6'b100000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0));
        step(1'b0, "div_c8", W(6'b010000, 3'b000, 3'b000, 1'b1, 1'b1, 1'b0, 3'd0));
        step(1'b0, "div_c9", W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'd0));
        step(1'b0, "div_c10", W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0));

        // Sqrt, n=3
        bus.op_type = 1'b1;
        step(1'b1, "sqrt_c0", W(6'b000010, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0));
        step(1'b0, "sqrt_c1", W(6'b001000, 3'b010, 3'b001, 1'b0, 1'b1, 1'b0, 3'd0));
        step(1'b0, "sqrt_c2", W(6'b000101, 3'b001, 3'b100, 1'b0, 1'b1, 1'b0, 3'd0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, "sqrt_b",  W(6'b000010, 3'b011, 3'b011, 1'b0, 1'b1, 1'b0, 3'(i + 1)));
            step(1'b0, "sqrt_d",  W(6'b001000, 3'b000, 3'b011, 1'b0, 1'b1, 1'b0, 3'd0));
            step(1'b0, "sqrt_ac", W(6'b000101, 3'b100, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0));
        end
        step(1'b0, "sqrt_c12", W(6'b100000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0));
        step(1'b0, "sqrt_c13", W(6'b010000, 3'b011, 3'b110, 1'b1, 1'b1, 1'b0, 3'd0));
        step(1'b0, "sqrt_c14", W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'd0));

        // Iteration-count boundaries (NITER_MAX=6 here, so 7 saturates)
        run_len("div_n1", 1'b0, 3'd1, 5, 3'd1);
        run_len("div_n0", 1'b0, 3'd0, 5, 3'd1);
        run_len("div_nsat", 1'b0, 3'd7, 2 * NITER_MAX + 3, 3'(NITER_MAX));
        run_len("sqrt_n2", 1'b1, 3'd2, 11, 3'd2);

        // Operand error
        bus.op_type = 1'b0;
        bus.niter   = 3'd3;
        bus.error   = 1'b1;
        step(1'b1, "err_c0", W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0));
        step(1'b0, "err_c1", W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'd0));
        step(1'b0, "err_c2", W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0));
        bus.error = 1'b0;

        // Abort in sqrt S_AC at cycle 5
        bus.op_type = 1'b1;
        bus.niter   = 3'd3;
        tick_in(1'b1);
        for (int i = 1; i < 5; i++) tick_in(1'b0);
        tick_in(1'b0);
        bus.abort = 1'b1;
        #1;
        chk("abt_c5", 32'(obs_w), 32'(W(6'b000000, 3'b100, 3'b010, 1'b0, 1'b1, 1'b0, 3'd0)));
        tick_in(1'b0);
        bus.abort = 1'b0;
        #1;
        chk("abt_c6", 32'(obs_w), 32'd0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick_in(1'b0);
            #1;
            if (bus.done) ndone++;
        end
        chk("abt_nodone", 32'(ndone), 32'd0);
        run_len("post_abt", 1'b0, 3'd1, 5, 3'd1);

        // Abort in DONE still pulses done
        bus.op_type = 1'b0;
        tick_in(1'b1);
        for (int i = 1; i < 5; i++) tick_in(1'b0);
        tick_in(1'b0);
        bus.abort = 1'b1;
        #1;
        chk("abt_in_done", 32'(obs_w), 32'(W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'd0)));
        tick_in(1'b0);
        bus.abort = 1'b0;
        #1;
        chk("abt_in_done_idle", 32'(obs_w), 32'd0);

        // Asynchronous reset mid-divide
        bus.niter = 3'd3;
        tick_in(1'b1);
        for (int i = 1; i < 4; i++) tick_in(1'b0);
        tick_in(1'b0);
        #1;
        chk("rst_pre", 32'(obs_w), 32'(W(6'b000010, 3'b011, 3'b011, 1'b0, 1'b1, 1'b0, 3'd2)));
        reset = 1'b0;
        #1;
        chk("rst_async", 32'(obs_w), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_len("post_rst", 1'b0, 3'd3, 9, 3'd3);

        // Start held high across DONE
        bus.niter = 3'd1;
        tick_in(1'b1);
        for (int i = 1; i < 5; i++) tick_in(1'b1);
        tick_in(1'b1);
        #1;
        chk("hold_done", 32'(obs_w), 32'(W(6'b000000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'd0)));
        step(1'b1, "hold_idle", W(6'b000010, 3'b001, 3'b001, 1'b0, 1'b0, 1'b0, 3'd0));
        step(1'b0, "hold_init", W(6'b000101, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 3'd0));
        k = -1;
        for (int i = 1; i < 20 && k < 0; i++) begin
            tick_in(1'b0);
            #1;
            if (bus.done) k = i;
        end
        chk("hold_second_done", 32'(k), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
